// File: rtl/regfile_wb_arbiter.sv
// Regfile write-back arbiter: merges the in-order pipeline WB write with results buffered
// from the muldiv unit, forcing a buffer drain when it fills or its head starves.
module regfile_wb_arbiter #(
    parameter int unsigned MD_DEPTH     = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic [31:0] regfile_in,
    output logic [4:0]  dest,
    output logic        load_regfile
);

    localparam int unsigned PW       = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
    localparam logic [2:0]    DEPTH_C  = 3'(MD_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(MD_DEPTH - 1);
    localparam logic [3:0]    LIMIT_C  = 4'(STARVE_LIMIT);

    typedef enum logic {StNorm, StForce} state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [4:0]    r_rd   [MD_DEPTH];
    logic [31:0]   r_data [MD_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [2:0]    r_count;
    logic [3:0]    r_starve;

    logic          w_push;
    logic          w_pop;
    logic          w_grant_pipe;
    logic          w_nonempty;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;
    logic [2:0]    w_count_nxt;
    logic [3:0]    w_starve_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // While rst is low every output is held at its reset value.
    assign md_ready    = !rst || (r_count < DEPTH_C);
    assign w_push      = md_valid & md_ready;
    assign w_nonempty  = (r_count != 3'd0);
    assign w_head_rd   = r_rd[r_rptr];
    assign w_head_data = r_data[r_rptr];

    always_comb begin
        w_grant_pipe = 1'b0;
        w_pop        = 1'b0;
        pipe_stall   = 1'b0;
        if (rst) begin
            unique case (r_state)
                StNorm: begin
                    if (pipe_valid) begin
                        w_grant_pipe = 1'b1;
                    end else begin
                        w_pop = w_nonempty;
                    end
                end
                StForce: begin
                    pipe_stall = 1'b1;
                    w_pop      = w_nonempty;
                end
                default: ;
            endcase
        end
    end

    // A granted write to x0 is still consumed; it just does not enable the regfile.
    always_comb begin
        load_regfile = 1'b0;
        dest         = 5'd0;
        regfile_in   = 32'd0;
        if (w_grant_pipe) begin
            dest         = pipe_rd;
            regfile_in   = pipe_data;
            load_regfile = (pipe_rd != 5'd0);
        end else if (w_pop) begin
            dest         = w_head_rd;
            regfile_in   = w_head_data;
            load_regfile = (w_head_rd != 5'd0);
        end
    end

    always_comb begin
        w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};
        if (w_pop || (w_count_nxt == 3'd0)) begin
            w_starve_nxt = 4'd0;
        end else if (w_nonempty && (r_starve < LIMIT_C)) begin
            w_starve_nxt = r_starve + 4'd1;
        end else begin
            w_starve_nxt = r_starve;
        end
    end

    // FORCE lasts exactly one cycle: its single pop relieves both full and starved conditions.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StNorm: begin
                if ((w_count_nxt == DEPTH_C) ||
                    ((w_starve_nxt == LIMIT_C) && (w_count_nxt != 3'd0))) begin
                    w_state_nxt = StForce;
                end
            end
            StForce: w_state_nxt = StNorm;
            default: w_state_nxt = StNorm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= StNorm;
            r_count  <= 3'd0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_starve <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_starve <= w_starve_nxt;
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_rd[r_wptr]   <= md_rd;
            r_data[r_wptr] <= md_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios followed by randomized traffic, each cycle compared against a
// queue-based reference model of the write-back arbitration rules.
module tb_regfile_wb_arbiter;

    localparam int MD_DEPTH     = 2;
    localparam int STARVE_LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic [31:0] regfile_in;
    logic [4:0]  dest;
    logic        load_regfile;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .MD_DEPTH     (MD_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_valid   (pipe_valid),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .pipe_stall   (pipe_stall),
        .md_valid     (md_valid),
        .md_rd        (md_rd),
        .md_data      (md_data),
        .md_ready     (md_ready),
        .regfile_in   (regfile_in),
        .dest         (dest),
        .load_regfile (load_regfile)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: buffered results as a queue, a one-shot drain flag, a starvation age.
    logic [4:0]  q_rd   [$];
    logic [31:0] q_data [$];
    bit          m_force;
    int          m_starve;

    logic        e_stall, e_ready, e_load, e_pop, e_push;
    logic [4:0]  e_dest;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit grant_pipe;
        grant_pipe = 1'b0;
        e_pop      = 1'b0;
        e_push     = 1'b0;
        e_stall    = 1'b0;
        e_ready    = 1'b1;
        if (rst) begin
            e_ready = (q_rd.size() < MD_DEPTH);
            e_push  = md_valid && e_ready;
            if (m_force) begin
                e_stall = 1'b1;
                e_pop   = (q_rd.size() > 0);
            end else if (pipe_valid) begin
                grant_pipe = 1'b1;
            end else begin
                e_pop = (q_rd.size() > 0);
            end
        end
        e_dest = 5'd0;
        e_data = 32'd0;
        e_load = 1'b0;
        if (grant_pipe) begin
            e_dest = pipe_rd;
            e_data = pipe_data;
            e_load = (pipe_rd != 5'd0);
        end else if (e_pop) begin
            e_dest = q_rd[0];
            e_data = q_data[0];
            e_load = (q_rd[0] != 5'd0);
        end
    endtask

    task automatic model_step();
        int old_n, n, s;
        if (!rst) begin
            q_rd.delete();
            q_data.delete();
            m_force  = 1'b0;
            m_starve = 0;
        end else begin
            old_n = q_rd.size();
            if (e_pop) begin
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end
            if (e_push) begin
                q_rd.push_back(md_rd);
                q_data.push_back(md_data);
            end
            n = q_rd.size();
            if (e_pop || n == 0) s = 0;
            else if (old_n > 0) s = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
            else s = m_starve;
            m_force  = !m_force && ((n == MD_DEPTH) || (s == STARVE_LIMIT && n > 0));
            m_starve = s;
        end
    endtask

    task automatic settle(input string tag);
        #1;
        model_eval();
        chk({tag, ".pipe_stall"}, 32'(pipe_stall), 32'(e_stall));
        chk({tag, ".md_ready"}, 32'(md_ready), 32'(e_ready));
        chk({tag, ".load_regfile"}, 32'(load_regfile), 32'(e_load));
        chk({tag, ".dest"}, 32'(dest), 32'(e_dest));
        chk({tag, ".regfile_in"}, regfile_in, e_data);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        pipe_valid = pv;
        pipe_rd    = prd;
        pipe_data  = pd;
        md_valid   = mv;
        md_rd      = mrd;
        md_data    = md;
    endtask

    task automatic cycle(input string tag);
        settle(tag);
        advance();
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 5'd2, 32'h55, 1'b1, 5'd3, 32'h66);
        @(negedge clk);

        // Reset asserted with live inputs: outputs must stay at reset values.
        settle("rst_busy");
        chk("rst_busy.load_const", 32'(load_regfile), 32'd0);
        chk("rst_busy.ready_const", 32'(md_ready), 32'd1);
        advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle("rst_idle");
        rst = 1'b1;
        settle("after_rst");
        chk("after_rst.dest_const", 32'(dest), 32'd0);
        advance();

        // Scenario 1: pipeline write with empty buffer.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        settle("s1");
        chk("s1.dest_const", 32'(dest), 32'd5);
        chk("s1.data_const", regfile_in, 32'hDEADBEEF);
        chk("s1.load_const", 32'(load_regfile), 32'd1);
        advance();

        // Scenario 2: single md push drained the next idle cycle.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12);
        cycle("s2_push");
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle("s2_pop");
        chk("s2_pop.dest_const", 32'(dest), 32'd7);
        chk("s2_pop.data_const", regfile_in, 32'h12);
        chk("s2_pop.load_const", 32'(load_regfile), 32'd1);
        advance();
        settle("s2_empty");
        chk("s2_empty.load_const", 32'(load_regfile), 32'd0);
        advance();

        // Scenario 3: buffer fills under continuous pipeline traffic.
        drive(1'b1, 5'd10, 32'hC0FFEE, 1'b1, 5'd3, 32'hA);
        cycle("s3_push0");
        drive(1'b1, 5'd10, 32'hC0FFEE, 1'b1, 5'd4, 32'hB);
        cycle("s3_push1");
        drive(1'b1, 5'd10, 32'hC0FFEE, 1'b0, 5'd0, 32'd0);
        settle("s3_force");
        chk("s3_force.stall_const", 32'(pipe_stall), 32'd1);
        chk("s3_force.ready_const", 32'(md_ready), 32'd0);
        chk("s3_force.dest_const", 32'(dest), 32'd3);
        chk("s3_force.data_const", regfile_in, 32'hA);
        advance();
        settle("s3_norm");
        chk("s3_norm.stall_const", 32'(pipe_stall), 32'd0);
        chk("s3_norm.dest_const", 32'(dest), 32'd10);
        advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle("s3_drain");
        chk("s3_drain.dest_const", 32'(dest), 32'd4);
        advance();

        // Scenario 4: one buffered entry starves for three cycles, then is forced out.
        drive(1'b1, 5'd11, 32'h1111, 1'b1, 5'd9, 32'h99);
        cycle("s4_push");
        drive(1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            settle("s4_wait");
            chk("s4_wait.stall_const", 32'(pipe_stall), 32'd0);
            advance();
        end
        settle("s4_force");
        chk("s4_force.stall_const", 32'(pipe_stall), 32'd1);
        chk("s4_force.dest_const", 32'(dest), 32'd9);
        advance();
        cycle("s4_norm");
        // A fresh entry must again wait the full starvation window.
        drive(1'b1, 5'd11, 32'h1111, 1'b1, 5'd8, 32'h88);
        cycle("s4_push2");
        drive(1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < STARVE_LIMIT + 2; i++) cycle("s4_again");

        // Scenario 5: writes to x0 are consumed without enabling the regfile.
        drive(1'b1, 5'd0, 32'h5A5A, 1'b1, 5'd0, 32'h77);
        settle("s5_pipe");
        chk("s5_pipe.load_const", 32'(load_regfile), 32'd0);
        chk("s5_pipe.stall_const", 32'(pipe_stall), 32'd0);
        advance();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle("s5_md");
        chk("s5_md.load_const", 32'(load_regfile), 32'd0);
        advance();
        cycle("s5_empty");

        // Scenario 6: reset lands in a FORCE cycle and discards the buffer.
        drive(1'b1, 5'd12, 32'h2222, 1'b1, 5'd13, 32'h33);
        cycle("s6_push0");
        drive(1'b1, 5'd12, 32'h2222, 1'b1, 5'd14, 32'h44);
        cycle("s6_push1");
        drive(1'b1, 5'd12, 32'h2222, 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        cycle("s6_rst");
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        settle("s6_after");
        chk("s6_after.ready_const", 32'(md_ready), 32'd1);
        chk("s6_after.load_const", 32'(load_regfile), 32'd0);
        advance();
        cycle("s6_empty");

        // Randomized traffic; the pipeline and muldiv unit hold their offers while refused.
        for (int i = 0; i < 400; i++) begin
            if (!(pipe_valid && e_stall && rst)) begin
                pipe_valid = ($urandom_range(0, 3) != 0);
                pipe_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pipe_data  = $urandom;
            end
            if (!(md_valid && !e_push && rst)) begin
                md_valid = ($urandom_range(0, 9) < 4);
                md_rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                md_data  = $urandom;
            end
            rst = ($urandom_range(0, 63) != 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter MD_DEPTH, default 2: number of muldiv result buffer entries; legal values 1-4.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3: number of consecutive cycles a non-empty buffer may go unserved before it is forced; legal values 1-15.
REQ-003 clk  in  1  clock; all state updates occur on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low (rst=0 resets on the next clk rising edge).
REQ-005 pipe_valid  in  1  in-order pipeline WB stage presents a write this cycle.
REQ-006 pipe_rd  in  5  destination register of the pipeline write.
REQ-007 pipe_data  in  32  write data of the pipeline write.
REQ-008 pipe_stall  out  1  pipeline WB write not accepted; WB stage holds its inputs.
REQ-009 md_valid  in  1  muldiv unit offers a result.
REQ-010 md_rd  in  5  destination register of the muldiv result.
REQ-011 md_data  in  32  muldiv result data.
REQ-012 md_ready  out  1  buffer accepts the muldiv result; push = md_valid & md_ready.
REQ-013 regfile_in  out  32  regfile write data.
REQ-014 dest  out  5  regfile write address.
REQ-015 load_regfile  out  1  regfile write enable.

Function
REQ-016 SHALL hold muldiv results in an in-order FIFO of MD_DEPTH entries, each entry {rd, data}; count ranges 0..MD_DEPTH.
REQ-017 md_ready SHALL equal (count < MD_DEPTH), using the registered count only; a push when full is impossible.
REQ-018 SHALL implement FSM states NORM and FORCE; the state is registered.
REQ-019 In NORM: if pipe_valid=1, the pipeline write is granted and pipe_stall=0; else if count>0, the FIFO head is granted and popped.
REQ-020 In FORCE: the FIFO head is granted and popped, and pipe_stall=1 regardless of pipe_valid.
REQ-021 NORM->FORCE SHALL occur at the edge where the next-cycle count equals MD_DEPTH, or where the next-cycle starve_cnt equals STARVE_LIMIT and the next-cycle count is greater than 0.
REQ-022 FORCE->NORM SHALL occur unconditionally after one cycle, since exactly one pop occurs in FORCE.
REQ-023 starve_cnt (4-bit) SHALL reset to 0 on any pop or when the next-cycle count is 0; otherwise it SHALL increment when count>0, saturating at STARVE_LIMIT.
REQ-024 When granted, dest and regfile_in SHALL carry the granted source's rd and data; load_regfile=1 only if the grantee is valid and rd!=0.
REQ-025 A granted write with rd=0 SHALL still be consumed (pipeline advances, or FIFO pops) with load_regfile=0.
REQ-026 When no write is granted: load_regfile=0, dest=0, regfile_in=0.
REQ-027 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; pointers wrap modulo MD_DEPTH.
REQ-028 pipe_stall SHALL be 0 in NORM; a pipeline write is never dropped or duplicated.
REQ-029 Ordering hazards between a pipeline write and a buffered result with the same rd SHALL be prevented upstream by issue logic; this block does not reorder or compare rd values.

Reset
REQ-030 On rst=0: state=NORM, count=0, rd/wr pointers=0, starve_cnt=0; buffered contents are discarded, including during FORCE.
REQ-031 During and in the first cycle after reset: load_regfile=0, pipe_stall=0, md_ready=1, dest=0, regfile_in=0.

Verification
REQ-032 Scenario 1: pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF, buffer empty -> same cycle load_regfile=1, dest=5, regfile_in=0xDEADBEEF, pipe_stall=0.
REQ-033 Scenario 2: pipe_valid=0 and one md push {rd=7, data=0x12} -> next cycle dest=7, regfile_in=0x12, load_regfile=1; count returns to 0.
REQ-034 Scenario 3: pipe_valid=1 continuously and md pushes {3,0xA} then {4,0xB} on back-to-back cycles (MD_DEPTH=2) -> count=2, md_ready=0, FORCE entered; the FORCE cycle writes rd=3 with pipe_stall=1; the next cycle returns to NORM.
REQ-035 Scenario 4: pipe_valid=1 continuously and one md push -> after 3 unserved cycles FORCE pops it; starve_cnt returns to 0.
REQ-036 Scenario 5: pipe_valid=1, pipe_rd=0 -> load_regfile=0, pipe_stall=0; an md entry with rd=0 pops with load_regfile=0.
REQ-037 Scenario 6: buffer holds 2 entries and rst=0 is applied during FORCE -> next cycle count=0, state=NORM, md_ready=1, load_regfile=0.
